// File: rtl/ccff_loader_pkg.sv
// ----------------------------------------------------------------------------
// ccff_loader_pkg
// Shared types and helpers for the CCFF bitstream loader.
//   ccff_ld_state_t : loader state machine encoding (IDLE, LOAD, DONE)
//   cntWidth()      : number of bits needed to hold the values 0..maxVal
// ----------------------------------------------------------------------------
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ccff_ld_state_t;

    // Counter width for a counter that must reach maxVal inclusive; never
    // narrower than one bit so degenerate parameters still elaborate.
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/ccff_readback_capture.sv
// ----------------------------------------------------------------------------
// ccff_readback_capture
// Collects the bits leaving the CCFF chain on ccff_tail and packs them into
// readback words, first bit out landing in bit 0. A word is emitted after
// WORD_W captures; on the final shift of a load any partial word is emitted
// right-aligned with its upper bits zero.
// Ports:
//   prog_clk, prog_reset : clock and synchronous active-high reset
//   i_capture            : chain shifts this cycle, sample i_tail
//   i_flush              : this capture is the last one of the load
//   i_tail               : serial data from the chain tail
//   o_rbData, o_rbValid  : readback word and its one-cycle qualifier
// ----------------------------------------------------------------------------
module ccff_readback_capture
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              i_capture,
    input  logic              i_flush,
    input  logic              i_tail,
    output logic [WORD_W-1:0] o_rbData,
    output logic              o_rbValid
);

    localparam int IDX_W = cntWidth(WORD_W - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    logic [WORD_W-1:0] r_buf;
    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] r_rbData;
    logic              r_rbValid;
    logic [WORD_W-1:0] w_next;
    logic              w_full;

    // Bits are written straight into their final position, so a partial word
    // is already right-aligned and the buffer only needs clearing after emit.
    assign w_next = r_buf | (WORD_W'(i_tail) << r_idx);
    assign w_full = (r_idx == LAST_IDX);

    // Capture register with word emit; rb_valid is a single-cycle pulse.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_buf     <= '0;
            r_idx     <= '0;
            r_rbData  <= '0;
            r_rbValid <= 1'b0;
        end else begin
            r_rbValid <= 1'b0;
            if (i_capture) begin
                if (w_full || i_flush) begin
                    r_rbData  <= w_next;
                    r_rbValid <= 1'b1;
                    r_buf     <= '0;
                    r_idx     <= '0;
                end else begin
                    r_buf <= w_next;
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign o_rbData  = r_rbData;
    assign o_rbValid = r_rbValid;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// ----------------------------------------------------------------------------
// ccff_bitstream_loader
// Serializes configuration words into the clb/fle CCFF chain, LSB-first,
// exactly CHAIN_LEN bits per load, one bit per cycle with ccff_shift_en high.
// Words arrive on a valid/ready handshake; a new word can replace the last
// bit of the current one in the same edge, so continuous words leave no gap.
// Optional readback of the previous chain contents is enabled by defining the
// macro CCFF_LOADER_READBACK_EN; without it rb_data/rb_valid are tied to 0.
// Ports:
//   prog_clk, prog_reset     : clock and synchronous active-high reset
//   start                    : begin a load (only honoured in IDLE)
//   cfg_data/valid/ready     : configuration word handshake
//   ccff_head, ccff_shift_en : serial data and shift enable into the chain
//   ccff_tail                : serial data out of the chain
//   busy, done               : busy in LOAD/DONE, done pulses once per load
//   rb_data, rb_valid        : readback word and its one-cycle qualifier
// ----------------------------------------------------------------------------
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 20,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);

    localparam int CNT_W = cntWidth(CHAIN_LEN);
    localparam int WB_W  = cntWidth(WORD_W);
    localparam int SUM_W = ((CNT_W > WB_W) ? CNT_W : WB_W) + 1;
    localparam logic [SUM_W-1:0] CHAIN_LEN_S = SUM_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WB_W-1:0]  FULL_WORD   = WB_W'(WORD_W);

    ccff_ld_state_t    r_state;
    logic [WORD_W-1:0] r_sreg;
    logic [WB_W-1:0]   r_wbit;
    logic [CNT_W-1:0]  r_bitsDone;

    logic             w_inLoad;
    logic [SUM_W-1:0] w_pending;
    logic             w_ready;
    logic             w_xfer;
    logic             w_shift;
    logic             w_lastShift;

    // Accept a word only when the current one is on its last bit (or empty)
    // and the bits already committed still fall short of the chain length, so
    // no word is ever accepted that would not get at least one bit shifted.
    assign w_inLoad    = (r_state == LOAD);
    assign w_pending   = SUM_W'(r_bitsDone) + SUM_W'(r_wbit);
    assign w_ready     = w_inLoad && (r_wbit <= WB_W'(1)) && (w_pending < CHAIN_LEN_S);
    assign w_xfer      = w_ready && cfg_valid;
    assign w_shift     = w_inLoad && (r_wbit != '0);
    assign w_lastShift = w_shift && (r_bitsDone == LAST_BIT);

    // Loader FSM with the shift register and both counters. When the last
    // buffered bit goes out without a replacement word, sreg is left alone
    // so ccff_head keeps showing that bit through the starvation gap.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_state    <= IDLE;
            r_sreg     <= '0;
            r_wbit     <= '0;
            r_bitsDone <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= LOAD;
                        r_wbit     <= '0;
                        r_bitsDone <= '0;
                    end
                end
                LOAD: begin
                    if (w_lastShift) begin
                        r_state    <= DONE;
                        r_wbit     <= '0;
                        r_bitsDone <= r_bitsDone + 1'b1;
                    end else begin
                        if (w_shift) begin
                            r_bitsDone <= r_bitsDone + 1'b1;
                        end
                        if (w_xfer) begin
                            r_sreg <= cfg_data;
                            r_wbit <= FULL_WORD;
                        end else if (w_shift) begin
                            r_wbit <= r_wbit - 1'b1;
                            if (r_wbit != WB_W'(1)) begin
                                r_sreg <= r_sreg >> 1;
                            end
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cfg_ready     = w_ready;
    assign ccff_shift_en = w_shift;
    assign ccff_head     = r_sreg[0];
    assign busy          = (r_state != IDLE);
    assign done          = (r_state == DONE);

`ifdef CCFF_LOADER_READBACK_EN
    // Every shift edge also pushes one old bit out of the tail; capture it.
    ccff_readback_capture #(
        .WORD_W (WORD_W)
    ) u_readback (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .i_capture  (w_shift),
        .i_flush    (w_lastShift),
        .i_tail     (ccff_tail),
        .o_rbData   (rb_data),
        .o_rbValid  (rb_valid)
    );
`else
    logic w_unusedTail;
    assign w_unusedTail = ccff_tail;
    assign rb_data      = '0;
    assign rb_valid     = 1'b0;
`endif

endmodule
